// File: rtl/peak_tracker_pkg.sv
// Shared defaults, FSM states and amplitude type for the spectral peak tracker.
package peak_tracker_pkg;

    localparam int DEF_FREQS              = 256;
    localparam int DEF_INPUT_AMPL_WIDTH   = 24;
    localparam int DEF_FINAL_AMPL_WIDTH   = 16;
    localparam int DEF_PEAKS              = 6;
    localparam int DEF_TIME_COUNTER_WIDTH = 16;

    // Inclusive upper frequency of each band; the last entry closes the frame.
    localparam int DEF_BAND_EDGE [DEF_PEAKS] = '{9, 19, 39, 79, 159, 255};

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        EMIT
    } state_t;

    typedef logic signed [DEF_INPUT_AMPL_WIDTH-1:0] ampl_t;

endpackage

// File: rtl/peak_cmp5.sv
// Five-point signed local-maximum test: centre must be >= all four neighbours.
module peak_cmp5
    import peak_tracker_pkg::*;
#(
    parameter int WIDTH = DEF_INPUT_AMPL_WIDTH
) (
    input  logic signed [WIDTH-1:0] i_centre,
    input  logic signed [WIDTH-1:0] i_north,
    input  logic signed [WIDTH-1:0] i_south,
    input  logic signed [WIDTH-1:0] i_east,
    input  logic signed [WIDTH-1:0] i_west,
    output logic                    o_isPeak
);

    assign o_isPeak = (i_centre >= i_north) && (i_centre >= i_south) &&
                      (i_centre >= i_east)  && (i_centre >= i_west);

endmodule

// File: rtl/peak_tracker.sv
// Three-frame sliding window peak tracker: scans the centre frame one bin per
// clock and reports the strongest above-threshold local maximum per band.
module peak_tracker
    import peak_tracker_pkg::*;
#(
    parameter int FREQS              = DEF_FREQS,
    parameter int INPUT_AMPL_WIDTH   = DEF_INPUT_AMPL_WIDTH,
    parameter int FINAL_AMPL_WIDTH   = DEF_FINAL_AMPL_WIDTH,
    parameter int PEAKS              = DEF_PEAKS,
    parameter int FREQ_WIDTH         = $clog2(FREQS),
    parameter int TIME_COUNTER_WIDTH = DEF_TIME_COUNTER_WIDTH,
    parameter int BAND_EDGE [PEAKS]  = DEF_BAND_EDGE
) (
    input  logic                               CLOCK_50,
    input  logic                               reset,
    input  logic                               frame_valid,
    output logic                               frame_ready,
    input  logic signed [INPUT_AMPL_WIDTH-1:0] fft_in [FREQS],
    input  logic signed [INPUT_AMPL_WIDTH-1:0] threshold,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic signed [FINAL_AMPL_WIDTH-1:0] amplitudes_out [PEAKS],
    output logic [FREQ_WIDTH-1:0]              freqs_out [PEAKS],
    output logic                               peak_found [PEAKS],
    output logic [TIME_COUNTER_WIDTH-1:0]      counter_out
);

    localparam int BAND_WIDTH = (PEAKS > 1) ? $clog2(PEAKS) : 1;
    localparam logic [FREQ_WIDTH-1:0] LAST_K    = FREQ_WIDTH'(FREQS - 1);
    localparam logic [BAND_WIDTH-1:0] LAST_BAND = BAND_WIDTH'(PEAKS - 1);

    state_t                               r_state;
    logic                                 r_primed;
    logic [TIME_COUNTER_WIDTH-1:0]        r_frameCnt;
    logic [TIME_COUNTER_WIDTH-1:0]        r_scanCnt;
    logic signed [INPUT_AMPL_WIDTH-1:0]   r_prev [FREQS];
    logic signed [INPUT_AMPL_WIDTH-1:0]   r_curr [FREQS];
    logic signed [INPUT_AMPL_WIDTH-1:0]   r_next [FREQS];
    logic [FREQ_WIDTH-1:0]                r_k;
    logic [BAND_WIDTH-1:0]                r_band;
    logic signed [INPUT_AMPL_WIDTH-1:0]   r_best [PEAKS];
    logic [FREQ_WIDTH-1:0]                r_bestF [PEAKS];
    logic                                 r_found [PEAKS];

    logic                                 r_outValid;
    logic signed [FINAL_AMPL_WIDTH-1:0]   r_amp [PEAKS];
    logic [FREQ_WIDTH-1:0]                r_freq [PEAKS];
    logic                                 r_foundOut [PEAKS];
    logic [TIME_COUNTER_WIDTH-1:0]        r_cntOut;

    logic signed [INPUT_AMPL_WIDTH-1:0]   w_centre;
    logic signed [INPUT_AMPL_WIDTH-1:0]   w_north;
    logic signed [INPUT_AMPL_WIDTH-1:0]   w_south;
    logic                                 w_isPeak;
    logic                                 w_hit;
    logic                                 w_accept;
    logic                                 w_bandDone;
    logic signed [INPUT_AMPL_WIDTH-1:0]   w_bestNext [PEAKS];
    logic [FREQ_WIDTH-1:0]                w_bestFNext [PEAKS];
    logic                                 w_foundNext [PEAKS];

    assign frame_ready    = (r_state == IDLE);
    assign w_accept       = frame_valid && frame_ready;
    assign out_valid      = r_outValid;
    assign amplitudes_out = r_amp;
    assign freqs_out      = r_freq;
    assign peak_found     = r_foundOut;
    assign counter_out    = r_cntOut;

    // Frame edges have no spectral neighbour, so they compare against zero.
    assign w_centre   = r_curr[r_k];
    assign w_north    = (r_k == '0)     ? '0 : r_curr[r_k - FREQ_WIDTH'(1)];
    assign w_south    = (r_k == LAST_K) ? '0 : r_curr[r_k + FREQ_WIDTH'(1)];
    assign w_bandDone = (int'(r_k) == BAND_EDGE[r_band]);

    peak_cmp5 #(
        .WIDTH    (INPUT_AMPL_WIDTH)
    ) u_cmp (
        .i_centre (w_centre),
        .i_north  (w_north),
        .i_south  (w_south),
        .i_east   (r_prev[r_k]),
        .i_west   (r_next[r_k]),
        .o_isPeak (w_isPeak)
    );

    // Strict compare keeps the lowest frequency on equal amplitudes.
    always_comb begin
        w_bestNext  = r_best;
        w_bestFNext = r_bestF;
        w_foundNext = r_found;
        w_hit       = w_isPeak && (w_centre > r_best[r_band]);
        if (w_hit) begin
            w_bestNext[r_band]  = w_centre;
            w_bestFNext[r_band] = r_k;
            w_foundNext[r_band] = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_state    <= IDLE;
            r_primed   <= 1'b0;
            r_frameCnt <= '0;
            r_scanCnt  <= '0;
            r_k        <= '0;
            r_band     <= '0;
            r_outValid <= 1'b0;
            r_cntOut   <= '0;
            for (int i = 0; i < FREQS; i++) begin
                r_prev[i] <= '0;
                r_curr[i] <= '0;
                r_next[i] <= '0;
            end
            for (int b = 0; b < PEAKS; b++) begin
                r_best[b]     <= '0;
                r_bestF[b]    <= '0;
                r_found[b]    <= 1'b0;
                r_amp[b]      <= '0;
                r_freq[b]     <= '0;
                r_foundOut[b] <= 1'b0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_prev     <= r_curr;
                        r_curr     <= r_next;
                        r_next     <= fft_in;
                        r_frameCnt <= r_frameCnt + TIME_COUNTER_WIDTH'(1);
                        r_primed   <= 1'b1;
                        // The very first frame only fills the window.
                        if (r_primed) begin
                            r_state   <= SCAN;
                            r_k       <= '0;
                            r_band    <= '0;
                            r_scanCnt <= r_frameCnt - TIME_COUNTER_WIDTH'(1);
                            for (int b = 0; b < PEAKS; b++) begin
                                r_best[b]  <= threshold;
                                r_bestF[b] <= '0;
                                r_found[b] <= 1'b0;
                            end
                        end
                    end
                end

                SCAN: begin
                    r_best  <= w_bestNext;
                    r_bestF <= w_bestFNext;
                    r_found <= w_foundNext;
                    if (r_k == LAST_K) begin
                        r_state    <= EMIT;
                        r_outValid <= 1'b1;
                        r_cntOut   <= r_scanCnt;
                        for (int b = 0; b < PEAKS; b++) begin
                            r_amp[b]      <= w_foundNext[b] ?
                                             w_bestNext[b][INPUT_AMPL_WIDTH-1 -: FINAL_AMPL_WIDTH] : '0;
                            r_freq[b]     <= w_foundNext[b] ? w_bestFNext[b] : '0;
                            r_foundOut[b] <= w_foundNext[b];
                        end
                    end else begin
                        r_k <= r_k + FREQ_WIDTH'(1);
                        if (w_bandDone && (r_band != LAST_BAND)) begin
                            r_band <= r_band + BAND_WIDTH'(1);
                        end
                    end
                end

                EMIT: begin
                    if (out_ready) begin
                        r_state    <= IDLE;
                        r_outValid <= 1'b0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_peak_tracker.sv
// Directed bench for peak_tracker: a 16-bin/2-band instance plus a twin with a
// 4-bit timestamp sharing the same stimulus, checked against hand-worked values.
module tb_peak_tracker;

    localparam int NF = 16;
    localparam int NP = 2;
    localparam int AW = 24;
    localparam int FW = 16;
    localparam int KW = 4;
    localparam int TB_EDGE [NP] = '{7, 15};

    logic                 CLOCK_50 = 1'b0;
    logic                 reset;
    logic                 frameValid;
    logic                 outReady;
    logic signed [AW-1:0] fftIn [NF];
    logic signed [AW-1:0] threshold;

    logic                 frameReady;
    logic                 outValid;
    logic signed [FW-1:0] ampOut [NP];
    logic [KW-1:0]        freqOut [NP];
    logic                 peakFound [NP];
    logic [15:0]          counterOut;

    logic                 wFrameReady;
    logic                 wOutValid;
    logic signed [FW-1:0] wAmpOut [NP];
    logic [KW-1:0]        wFreqOut [NP];
    logic                 wPeakFound [NP];
    logic [3:0]           wCounterOut;

    logic signed [AW-1:0] frame [NF];
    int                   total = 0;
    int                   bad = 0;
    int                   stallBad;

    always #10 CLOCK_50 = ~CLOCK_50;

    peak_tracker #(
        .FREQS (NF), .PEAKS (NP), .BAND_EDGE (TB_EDGE)
    ) dut (
        .CLOCK_50       (CLOCK_50),
        .reset          (reset),
        .frame_valid    (frameValid),
        .frame_ready    (frameReady),
        .fft_in         (fftIn),
        .threshold      (threshold),
        .out_valid      (outValid),
        .out_ready      (outReady),
        .amplitudes_out (ampOut),
        .freqs_out      (freqOut),
        .peak_found     (peakFound),
        .counter_out    (counterOut)
    );

    peak_tracker #(
        .FREQS (NF), .PEAKS (NP), .BAND_EDGE (TB_EDGE), .TIME_COUNTER_WIDTH (4)
    ) dutWrap (
        .CLOCK_50       (CLOCK_50),
        .reset          (reset),
        .frame_valid    (frameValid),
        .frame_ready    (wFrameReady),
        .fft_in         (fftIn),
        .threshold      (threshold),
        .out_valid      (wOutValid),
        .out_ready      (outReady),
        .amplitudes_out (wAmpOut),
        .freqs_out      (wFreqOut),
        .peak_found     (wPeakFound),
        .counter_out    (wCounterOut)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    // Both instances see identical frames, so only the timestamps may differ.
    task automatic checkPeaks(input string tag,
                              input logic [31:0] f0, input logic [31:0] a0, input logic [31:0] p0,
                              input logic [31:0] f1, input logic [31:0] a1, input logic [31:0] p1,
                              input logic [31:0] cnt);
        checkOutput({tag, "_freq0"}, freqOut[0], f0);
        checkOutput({tag, "_amp0"}, ampOut[0], a0);
        checkOutput({tag, "_found0"}, peakFound[0], p0);
        checkOutput({tag, "_freq1"}, freqOut[1], f1);
        checkOutput({tag, "_amp1"}, ampOut[1], a1);
        checkOutput({tag, "_found1"}, peakFound[1], p1);
        checkOutput({tag, "_cnt"}, counterOut, cnt);
        checkOutput({tag, "_cntWrap"}, wCounterOut, cnt & 32'hF);
        checkOutput({tag, "_twinFreq1"}, wFreqOut[1], f1);
        checkOutput({tag, "_twinAmp0"}, wAmpOut[0], a0);
        checkOutput({tag, "_twinFound1"}, wPeakFound[1], p1);
    endtask

    task automatic clearFrame();
        for (int i = 0; i < NF; i++) frame[i] = '0;
    endtask

    // Offers the frame until accepted; returns on the negedge after the accept edge.
    task automatic applyStimulus(input logic signed [AW-1:0] thr);
        int n;
        @(negedge CLOCK_50);
        fftIn      = frame;
        threshold  = thr;
        frameValid = 1'b1;
        n = 0;
        while (!frameReady && n < 100) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (!frameReady) checkOutput("accept_timeout", 32'd0, 32'd1);
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        frameValid = 1'b0;
        threshold  = AW'($urandom);
        for (int i = 0; i < NF; i++) fftIn[i] = AW'($urandom);
    endtask

    task automatic waitValid(input string tag);
        int n;
        n = 0;
        while (!outValid && n < 40) begin
            @(negedge CLOCK_50);
            n++;
        end
        checkOutput({tag, "_valid"}, outValid, 32'd1);
    endtask

    task automatic checkNoValid(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge CLOCK_50);
            if (outValid || wOutValid) seen++;
        end
        checkOutput(tag, seen, 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        frameValid = 1'b0;
        outReady   = 1'b1;
        threshold  = '0;
        clearFrame();
        fftIn = frame;
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        @(negedge CLOCK_50);
        checkOutput("rst_ready", frameReady, 32'd1);
        checkOutput("rst_valid", outValid, 32'd0);
        checkPeaks("rst", 0, 0, 0, 0, 0, 0, 0);

        // A: warm-up frame only fills the window
        clearFrame();
        applyStimulus('0);
        checkNoValid("warmup_noValid", 20);
        checkOutput("warmup_ready", frameReady, 32'd1);

        // B: scans all-zero A, nothing beats a zero threshold
        clearFrame();
        frame[3]  = 24'sh100000;
        frame[12] = 24'sh200000;
        applyStimulus('0);
        waitValid("scanA");
        checkPeaks("scanA", 0, 0, 0, 0, 0, 0, 0);

        // C: scans B, exact latency
        clearFrame();
        applyStimulus('0);
        repeat (15) @(negedge CLOCK_50);
        checkOutput("lat_early", outValid, 32'd0);
        @(negedge CLOCK_50);
        checkOutput("lat_valid", outValid, 32'd1);
        checkPeaks("single", 3, 32'h1000, 1, 12, 32'h2000, 1, 1);

        // D: tie at bins 2 and 5
        clearFrame();
        frame[2]  = 24'sh050000;
        frame[5]  = 24'sh050000;
        applyStimulus('0);
        waitValid("scanC");
        clearFrame();
        applyStimulus('0);
        waitValid("scanD");
        checkPeaks("tie", 2, 32'h0500, 1, 0, 0, 0, 3);

        // F: same tie pattern plus bin 10, scanned with threshold 0x50000
        clearFrame();
        frame[2]  = 24'sh050000;
        frame[5]  = 24'sh050000;
        frame[10] = 24'sh060000;
        applyStimulus('0);
        waitValid("scanE");
        clearFrame();
        applyStimulus(24'sh050000);
        waitValid("scanF");
        checkPeaks("thresh", 0, 0, 0, 10, 32'h0600, 1, 5);

        // H then I: a louder earlier frame vetoes I's bin 3
        clearFrame();
        frame[3] = 24'sh300000;
        applyStimulus('0);
        waitValid("scanG");
        clearFrame();
        frame[3] = 24'sh100000;
        applyStimulus('0);
        waitValid("scanH");
        checkPeaks("scanH", 3, 32'h3000, 1, 0, 0, 0, 7);
        clearFrame();
        applyStimulus('0);
        waitValid("scanI");
        checkPeaks("temporal", 0, 0, 0, 0, 0, 0, 8);

        // K then L under backpressure
        clearFrame();
        frame[9] = 24'sh7FFF00;
        applyStimulus('0);
        waitValid("scanJ");
        checkPeaks("scanJ", 0, 0, 0, 0, 0, 0, 9);
        clearFrame();
        applyStimulus('0);
        outReady = 1'b0;
        waitValid("scanK");
        checkPeaks("scanK", 0, 0, 0, 9, 32'h7FFF, 1, 10);

        clearFrame();
        frame[6]   = 24'sh0A0000;
        fftIn      = frame;
        threshold  = '0;
        frameValid = 1'b1;
        stallBad   = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLOCK_50);
            if (outValid !== 1'b1 || frameReady !== 1'b0 || ampOut[1] !== 16'sh7FFF ||
                freqOut[1] !== 4'd9 || counterOut !== 16'd10)
                stallBad++;
        end
        checkOutput("stall_stable", stallBad, 32'd0);
        checkOutput("stall_ready", frameReady, 32'd0);
        outReady = 1'b1;
        @(negedge CLOCK_50);
        checkOutput("post_hs_ready", frameReady, 32'd1);
        checkOutput("post_hs_valid", outValid, 32'd0);
        checkOutput("post_hs_hold", ampOut[1], 32'h7FFF);
        @(negedge CLOCK_50);
        frameValid = 1'b0;
        for (int i = 0; i < NF; i++) fftIn[i] = AW'($urandom);
        waitValid("scanL");
        checkPeaks("scanL", 0, 0, 0, 0, 0, 0, 11);
        clearFrame();
        applyStimulus('0);
        waitValid("scanM");
        checkPeaks("scanM", 6, 32'h0A00, 1, 0, 0, 0, 12);

        // O: reset while scanning k=8
        clearFrame();
        frame[1] = 24'sh010000;
        applyStimulus('0);
        repeat (8) @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        checkOutput("midrst_ready", frameReady, 32'd1);
        checkOutput("midrst_valid", outValid, 32'd0);
        checkPeaks("midrst", 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        // P restarts warm-up, Q scans it with fresh timestamps
        clearFrame();
        frame[14] = 24'sh123456;
        applyStimulus('0);
        checkNoValid("rst_warmup_noValid", 20);
        clearFrame();
        applyStimulus('0);
        waitValid("scanP");
        checkPeaks("scanP", 0, 0, 0, 14, 32'h1234, 1, 0);

        // Frames 2..17 after reset: timestamps 15 and then 16 (0 on the 4-bit twin)
        for (int j = 2; j < 18; j++) begin
            clearFrame();
            applyStimulus('0);
            waitValid("wrapScan");
            if (j == 16) checkPeaks("wrap15", 0, 0, 0, 0, 0, 0, 15);
            if (j == 17) checkPeaks("wrap16", 0, 0, 0, 0, 0, 0, 16);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
